// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
//   Transmit stage of the UART. The register block pushes bytes into a FIFO.
//   The engine serialises each byte onto stx_pad_o as an asynchronous frame:
//   a start bit, 5-8 data bits LSB-first, an optional parity bit, then stop.
//   Bit timing comes from the 16x-baud enable strobe. FIFO level and FSM state
//   are reported back so the register block can build LSR[5]/LSR[6].
//
// Ports
//   clk          system clock
//   wb_rst_i     asynchronous active-high reset
//   lcr[7:0]     line control: [1:0] len-5, [2] stop, [3] PEN, [4] EPS,
//                [5] stick parity, [6] break
//   tf_push      1-clk strobe, push wb_dat_i into the FIFO
//   wb_dat_i     byte to push
//   enable       16x baud tick, 1-clk pulses
//   stx_pad_o    serial output, idle high
//   tstate       FSM state code (0 = idle)
//   tf_count     FIFO occupancy, 0..FIFO_DEPTH
//   tx_reset     1-clk strobe, flush the FIFO
//   lsr_mask     1-clk strobe, clear tf_overrun
//   tf_overrun   sticky flag, push attempted while the FIFO was full
//
// Handshake: there is no back-pressure. A tf_push strobe is accepted in the
// clock it is seen unless the FIFO is full (byte dropped, tf_overrun set) or
// tx_reset is active in the same clock (byte discarded).
// -----------------------------------------------------------------------------
module uart_tx_engine #(
   parameter int FIFO_DEPTH = 16,
   parameter int FIFO_CNT_W = 5,
   parameter int OVERSAMPLE = 16
) (
   input  logic                  clk,
   input  logic                  wb_rst_i,
   input  logic [7:0]            lcr,
   input  logic                  tf_push,
   input  logic [7:0]            wb_dat_i,
   input  logic                  enable,
   output logic                  stx_pad_o,
   output logic [2:0]            tstate,
   output logic [FIFO_CNT_W-1:0] tf_count,
   input  logic                  tx_reset,
   input  logic                  lsr_mask,
   output logic                  tf_overrun
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   // Period lengths in enable pulses: one bit, 1.5 stop bits, 2 stop bits.
   localparam logic [7:0] BIT_TICKS  = 8'(OVERSAMPLE);
   localparam logic [7:0] STOP15_TICKS = 8'(OVERSAMPLE + OVERSAMPLE / 2);
   localparam logic [7:0] STOP2_TICKS  = 8'(2 * OVERSAMPLE);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_POP    = 3'd5
   } tx_state_t;

   // ---------------------------------------------------------------- FIFO
   logic [7:0]            r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_head;
   logic [PTR_W-1:0]      r_tail;
   logic [FIFO_CNT_W-1:0] r_count;
   logic                  r_overrun;

   logic                  w_full;
   logic                  w_push_ok;
   logic                  w_pop;

   // ---------------------------------------------------------------- FSM
   tx_state_t             r_state;
   tx_state_t             w_next;
   logic [7:0]            r_tick;
   logic [2:0]            r_bit;
   logic [7:0]            r_data;
   logic [5:0]            r_lcr;
   logic                  r_stx;

   logic [7:0]            w_period;
   logic                  w_tick_done;
   logic                  w_last_bit;
   logic                  w_parity;
   logic                  w_stx_next;
   logic [7:0]            w_mask;

   assign w_full    = (r_count == FIFO_CNT_W'(FIFO_DEPTH));
   assign w_push_ok = tf_push && !w_full && !tx_reset;
   // POP with an empty FIFO can only follow a flush; nothing is popped then.
   assign w_pop     = (r_state == S_POP) && (r_count != '0);

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (tx_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_push_ok) r_tail <= r_tail + 1'b1;
            if (w_pop)     r_head <= r_head + 1'b1;
            case ({w_push_ok, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
         // A fresh overrun outranks a simultaneous clear.
         if (tf_push && w_full) r_overrun <= 1'b1;
         else if (lsr_mask)     r_overrun <= 1'b0;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_tail] <= wb_dat_i;
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      case (lcr[1:0])
         2'd0:    w_mask = 8'h1F;
         2'd1:    w_mask = 8'h3F;
         2'd2:    w_mask = 8'h7F;
         default: w_mask = 8'hFF;
      endcase
   end

   always_comb begin
      w_period = BIT_TICKS;
      if (r_state == S_STOP && r_lcr[2]) begin
         w_period = (r_lcr[1:0] == 2'd0) ? STOP15_TICKS : STOP2_TICKS;
      end
   end

   assign w_tick_done = enable && (r_tick == w_period - 8'd1);
   assign w_last_bit  = (r_bit == 3'd4 + {1'b0, r_lcr[1:0]});
   // Data is already masked to word length, so the reduction sees only real bits.
   assign w_parity    = r_lcr[5] ? ~r_lcr[4] : (r_lcr[4] ? ^r_data : ~^r_data);

   always_comb begin
      w_next     = r_state;
      w_stx_next = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (enable && r_count != '0) w_next = S_POP;
         end
         S_POP: begin
            w_next = (r_count != '0) ? S_START : S_IDLE;
         end
         S_START: begin
            w_stx_next = 1'b0;
            if (w_tick_done) w_next = S_DATA;
         end
         S_DATA: begin
            w_stx_next = r_data[r_bit];
            if (w_tick_done && w_last_bit) w_next = r_lcr[3] ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            w_stx_next = w_parity;
            if (w_tick_done) w_next = S_STOP;
         end
         S_STOP: begin
            if (w_tick_done) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- state regs
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state <= S_IDLE;
         r_tick  <= '0;
         r_bit   <= '0;
         r_data  <= '0;
         r_lcr   <= '0;
         r_stx   <= 1'b1;
      end else begin
         r_state <= w_next;
         r_stx   <= w_stx_next;

         // Tick counter only advances on enable; it restarts every period.
         if (r_state == S_IDLE || r_state == S_POP || w_tick_done) r_tick <= '0;
         else if (enable)                                          r_tick <= r_tick + 8'd1;

         if (r_state != S_DATA)  r_bit <= '0;
         else if (w_tick_done)   r_bit <= r_bit + 3'd1;

         // Frame format is frozen here so later lcr writes wait for the next frame.
         if (r_state == S_POP) begin
            r_data <= r_mem[r_head] & w_mask;
            r_lcr  <= lcr[5:0];
         end
      end
   end

   // ---------------------------------------------------------------- outputs
   // Break is applied after the register so it takes effect immediately.
   assign stx_pad_o  = r_stx & ~lcr[6];
   assign tstate     = r_state;
   assign tf_count   = r_count;
   assign tf_overrun = r_overrun;

endmodule
